// File: rtl/conv3d_window_mac_pkg.sv
// Shared constants and helpers for the 3D convolution window MAC engine:
// FSM state codes, tap-count calculation and the saturating rescale.
package conv3d_pkg;

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] OUT   = 2'd2;

  // Wide enough for any legal accumulator; narrower ones are sign-extended in.
  localparam int SAT_IN_W = 128;

  localparam logic signed [SAT_IN_W-1:0] SAT_HI = 128'sh7FFF_FFFF;
  localparam logic signed [SAT_IN_W-1:0] SAT_LO = -128'sh8000_0000;

  function automatic int calc_taps(input int kernel, input int in_ch);
    return in_ch * kernel * kernel * kernel;
  endfunction

  // Returns {sat, data[31:0]} for acc >>> frac clamped to the int32 range.
  function automatic logic [32:0] sat_shift(input logic signed [SAT_IN_W-1:0] acc,
                                            input int frac);
    logic signed [SAT_IN_W-1:0] r;
    r = acc >>> frac;
    if (r > SAT_HI) return {1'b1, 32'h7FFF_FFFF};
    if (r < SAT_LO) return {1'b1, 32'h8000_0000};
    return {1'b0, r[31:0]};
  endfunction

endpackage

// File: rtl/conv3d_window_mac_mul_pipe.sv
// Two-stage registered signed 32x32 multiplier carrying the tap's
// valid/first/last sideband alongside the operands.
module conv3d_mul_pipe
  import conv3d_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  output logic signed [63:0] product,
  output logic               out_first,
  output logic               out_last
);

  logic               s1_valid;
  logic               s1_first;
  logic               s1_last;
  logic signed [31:0] s1_a;
  logic signed [31:0] s1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // NOTE: datapath registers carry no reset; they are only ever read while
  // their stage valid is set, so resetting them would add fan-out for nothing.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_a     <= a;
      s1_b     <= b;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
    if (s1_valid) begin
      product   <= s1_a * s1_b;
      out_first <= s1_first;
      out_last  <= s1_last;
    end
  end

endmodule

// File: rtl/conv3d_window_mac.sv
// Gather-style 3D convolution MAC: accumulates one window of (voxel, weight)
// taps, adds an optional bias, rescales, saturates and hands off one result.
module conv3d_window_mac
  import conv3d_pkg::*;
#(
  parameter int KERNEL    = 3,
  parameter int IN_CH     = 1,
  parameter int FRAC_BITS = 16,
  parameter int BIAS_EN   = 1,
  parameter int ACC_W     = 72
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [31:0] input_data,
  input  logic [31:0] weight_data,
  input  logic [31:0] bias_data,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [31:0] output_data,
  output logic        sat_out
);

  localparam int TAPS  = calc_taps(KERNEL, IN_CH);
  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TAPS - 1);

  logic [1:0]              state;
  logic [CNT_W-1:0]        tap_cnt;
  logic                    accept;
  logic                    is_first;
  logic                    is_last;
  logic signed [31:0]      bias_q;

  logic                    p_valid;
  logic signed [63:0]      p_data;
  logic                    p_first;
  logic                    p_last;
  logic                    s3_last;

  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    preload;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [SAT_IN_W-1:0] acc_ext;

  assign ready_in  = (state == ACCUM);
  assign valid_out = (state == OUT);
  assign accept    = valid_in && ready_in;
  assign is_first  = (tap_cnt == '0);
  assign is_last   = (tap_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
      bias_q  <= '0;
    end else if (accept) begin
      tap_cnt <= is_last ? '0 : tap_cnt + CNT_W'(1);
      if (is_first) bias_q <= bias_data;
    end
  end

  conv3d_mul_pipe u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .a         (input_data),
    .b         (weight_data),
    .in_first  (is_first),
    .in_last   (is_last),
    .out_valid (p_valid),
    .product   (p_data),
    .out_first (p_first),
    .out_last  (p_last)
  );

  // Bias is in integer units, so it is aligned to the product's binary point.
  assign preload  = (BIAS_EN != 0) ? (ACC_W'(bias_q) <<< FRAC_BITS) : '0;
  assign prod_ext = ACC_W'(p_data);
  assign acc_ext  = SAT_IN_W'(acc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      s3_last <= 1'b0;
    end else begin
      s3_last <= p_valid && p_last;
      if (p_valid) acc <= (p_first ? preload : acc) + prod_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      output_data <= '0;
      sat_out     <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept && is_last) state <= FLUSH;
        FLUSH: begin
          // s3_last marks the cycle after the final tap landed in acc.
          if (s3_last) begin
            state                  <= OUT;
            {sat_out, output_data} <= sat_shift(acc_ext, FRAC_BITS);
          end
        end
        OUT:     if (ready_out) state <= ACCUM;
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/conv3d_window_mac.md
Name: conv3d_window_mac

Overview:
- Forward (gather) 3D convolution MAC engine: the adjoint of the transposed-conv scatter path.
- Consumes one output voxel's receptive field as a stream of (input voxel, weight) tap pairs: IN_CH*KERNEL^3 taps.
- Accumulates the taps through a pipelined signed multiplier, adds an optional bias, then rescales and saturates to 32 bits.
- Presents one result per window on a ready/valid output. Sits between the window-address generator and the output-voxel writer.

Parameters:
- KERNEL, 3: cubic kernel edge length (>=1).
- IN_CH, 1: input channels per window (>=1).
- FRAC_BITS, 16: fixed-point fraction bits of the product. Result = acc >>> FRAC_BITS.
- BIAS_EN, 1: 1 = preload accumulator with bias_data; 0 = preload zero.
- ACC_W, 72: accumulator width. Must be >= 64 + clog2(TAPS) + 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  tap pair valid
- ready_in  out  1  engine accepts tap this cycle
- input_data  in  32  signed input voxel
- weight_data  in  32  signed weight
- bias_data  in  32  signed bias (integer units), sampled with the first tap of each window
- valid_out  out  1  result valid
- ready_out  in  1  downstream accepts result
- output_data  out  32  signed saturated result
- sat_out  out  1  result was clipped; qualified by valid_out

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous active-low.
- Reset values:
  - state = ACCUM, so ready_in = 1 right after reset.
  - valid_out = 0, output_data = 0, sat_out = 0.
  - tap counter = 0, pipeline valids = 0, accumulator = 0.
- Derived constant: TAPS = IN_CH*KERNEL^3.
- Tap accept: a tap is accepted when valid_in && ready_in. Idle cycles between taps are allowed; pipeline bubbles never touch the accumulator.
- ready_in = (state == ACCUM), combinational from state.
- Pipeline, all stages gated by their own valid bit:
  - S1: register operands, first flag (tap_cnt == 0) and last flag (tap_cnt == TAPS-1).
  - S2: 64-bit signed product register.
  - S3: accumulate.
- Accumulation:
  - On an S3 valid with first flag: acc = preload + product.
  - preload = sign_extend(bias_data) << FRAC_BITS if BIAS_EN, else 0.
  - Otherwise: acc = acc + sign_extend(product).
- Tap counter: increments on each accept and wraps to 0 after TAPS-1.
- State machine:
  - ACCUM -> FLUSH when the accepted tap has tap_cnt == TAPS-1.
  - FLUSH: ready_in = 0. Waits until the last-flagged tap leaves S3 (exactly 3 cycles after accept), then -> OUT.
  - OUT: the result register drives valid_out = 1.
  - OUT -> ACCUM on valid_out && ready_out. valid_out falls the next cycle. Taps are accepted again from the cycle after the handshake.
- Result formation, registered on entry to OUT:
  - r = acc >>> FRAC_BITS.
  - If r > 2^31-1: output 0x7FFFFFFF, sat_out = 1.
  - If r < -2^31: output 0x80000000, sat_out = 1.
  - Otherwise: output r[31:0], sat_out = 0.
  - output_data and sat_out stay stable while valid_out = 1 && ready_out = 0.
- Timing:
  - Latency from last-tap accept to valid_out = 4 cycles.
  - Minimum window period = TAPS + 4 cycles with ready_out held high.
- Boundary conditions:
  - TAPS = 1: the first and last flags are on the same tap. Preload and add in the same cycle.
  - valid_in asserted while ready_in = 0: no accept, no state change. Upstream holds its data.
  - ready_out held low indefinitely: block stalls in OUT. No tap is lost or accepted.
  - Reset mid-window or in OUT: the partial window is discarded and all outputs return to their reset values asynchronously.
  - bias_data is sampled only with the first tap. Later changes are ignored.

Decomposition:
- Package conv3d_pkg:
  - function computing TAPS.
  - state enum {ACCUM, FLUSH, OUT}.
  - saturating right-shift function sat_shift(acc, FRAC_BITS) returning {sat, data[31:0]}.
- One sub-module: conv3d_mul_pipe, the 2-stage registered signed 32x32 multiplier with valid/first/last sideband.
- Counter, FSM, accumulator and output register stay in the top.

Test Plan:
- KERNEL=2, IN_CH=1, FRAC_BITS=0, BIAS_EN=0; 8 taps input=1..8, weight=1; ready_out=1 -> output_data=36, sat_out=0, valid_out rises 4 cycles after the 8th accept.
- Same config, BIAS_EN=1, bias_data=-40, taps input=2, weight=3 -> output_data=8. A bias_data change after the first tap has no effect.
- FRAC_BITS=16, KERNEL=1, IN_CH=1; input=0x00018000 (1.5), weight=0x00020000 (2.0) -> output_data=0x00030000.
- Saturation: KERNEL=2; 8 taps of input=0x7FFFFFFF, weight=0x7FFFFFFF, FRAC_BITS=0 -> output_data=0x7FFFFFFF, sat_out=1. Repeat with weight=0x80000001 -> 0x80000000, sat_out=1.
- Backpressure:
  - ready_out=0 for 10 cycles after valid_out: output_data stays stable, ready_in=0 throughout, valid_in taps are not accepted.
  - Then ready_out=1: ready_in=1 the next cycle. A second window of random gapped valid_in matches the reference model.
- Assert rst_n=0 after 5 of 8 taps, release, send a full window of input=1, weight=1 -> output_data=8. No residue from the aborted window.
